// File: rtl/axi_forwarding_arbiter_pkg.sv
// Shared definitions for the forwarding arbiter, CAM and crossbar top.
// State encoding and select-width helper.
package axi_forwarding_arbiter_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_forwarding_arbiter_if.sv
// Forwarding request/ack plus per-input and output AXI stream bundle.
// slave = arbiter side, master = crossbar/CAM side.
interface axi_forwarding_arbiter_if #(
  parameter int WIDTH      = 64,
  parameter int NUM_INPUTS = 2
);

  logic [NUM_INPUTS-1:0]       forward_req;
  logic [NUM_INPUTS-1:0]       forward_ack;
  logic [NUM_INPUTS*WIDTH-1:0] i_tdata;
  logic [NUM_INPUTS-1:0]       i_tlast;
  logic [NUM_INPUTS-1:0]       i_tvalid;
  logic [NUM_INPUTS-1:0]       i_tready;
  logic [WIDTH-1:0]            o_tdata;
  logic                        o_tlast;
  logic                        o_tvalid;
  logic                        o_tready;

  modport slave (
    input  forward_req, i_tdata, i_tlast,
    input  i_tvalid, o_tready,
    output forward_ack, i_tready,
    output o_tdata, o_tlast, o_tvalid
  );

  modport master (
    output forward_req, i_tdata, i_tlast,
    output i_tvalid, o_tready,
    input  forward_ack, i_tready,
    input  o_tdata, o_tlast, o_tvalid
  );

endinterface

// File: rtl/axi_forwarding_arbiter_rr_priority_encoder.sv
// Round-robin priority encoder: first set req bit after last, wrapping.
// Purely combinational; shared by the crossbar arbiters.
module rr_priority_encoder #(
  parameter int N  = 2,
  parameter int SW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] &&
            ((int'(last) + k) % N) == i) begin
          found  = 1'b1;
          idx    = SW'(i);
          gnt[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_forwarding_arbiter.sv
// Output-port forwarding arbiter: round-robin grant held for a packet,
// zero-latency stream mux, clear-on-read forwarded packet count.
module axi_forwarding_arbiter
  import axi_forwarding_arbiter_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int NUM_INPUTS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  axi_forwarding_arbiter_if.slave bus,
  output logic        busy,
  input  logic        pkt_count_rd_stb,
  output logic [31:0] pkt_count
);

  localparam int SW = sel_w(NUM_INPUTS);
  localparam logic [SW-1:0] LAST_RST = SW'(NUM_INPUTS - 1);

  logic [0:0]            state_q, state_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [SW-1:0]         last_q, last_d;
  logic [NUM_INPUTS-1:0] ack_q, ack_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [NUM_INPUTS-1:0] rr_gnt;
  logic [SW-1:0]         rr_idx;
  logic                  granted;
  logic                  eof;

  rr_priority_encoder #(
    .N  (NUM_INPUTS),
    .SW (SW)
  ) u_rr (
    .req  (bus.forward_req),
    .last (last_q),
    .gnt  (rr_gnt),
    .idx  (rr_idx)
  );

  assign granted         = (state_q == ST_GRANT);
  assign busy            = granted;
  assign bus.forward_ack = ack_q;
  assign pkt_count       = cnt_q;

  always_comb begin
    bus.o_tdata  = '0;
    bus.o_tlast  = 1'b0;
    bus.o_tvalid = 1'b0;
    bus.i_tready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (granted && sel_q == SW'(i)) begin
        bus.o_tdata     = bus.i_tdata[i*WIDTH +: WIDTH];
        bus.o_tlast     = bus.i_tlast[i];
        bus.o_tvalid    = bus.i_tvalid[i];
        bus.i_tready[i] = bus.o_tready;
      end
    end
  end

  // o_tvalid is already gated by the grant
  assign eof = bus.o_tvalid & bus.o_tready & bus.o_tlast;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    ack_d   = ack_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.forward_req) begin
          ack_d   = rr_gnt;
          sel_d   = rr_idx;
          last_d  = rr_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (eof) begin
          ack_d   = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // a read restarts the count, keeping an EOF in the read cycle
  always_comb begin
    cnt_d = cnt_q;
    if (pkt_count_rd_stb)
      cnt_d = {31'd0, eof};
    else if (eof && cnt_q != '1)
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= LAST_RST;
      ack_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_forwarding_arbiter.sv
// Bench for axi_forwarding_arbiter: per-input packet queues drive the
// bus; a protocol-level model predicts grants, beats and the count.
module tb_axi_forwarding_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        clear  = 1'b0;
  logic        rd_stb = 1'b0;
  logic        busy;
  logic [31:0] pkt_count;

  axi_forwarding_arbiter_if #(.WIDTH(W), .NUM_INPUTS(N)) bus ();

  axi_forwarding_arbiter #(.WIDTH(W), .NUM_INPUTS(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .clear            (clear),
    .bus              (bus.slave),
    .busy             (busy),
    .pkt_count_rd_stb (rd_stb),
    .pkt_count        (pkt_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [W:0]  src [N][$];
  int          owner  = -1;
  int          m_last = N - 1;
  logic [31:0] m_count = '0;
  bit          rdy = 1'b1;
  bit          vld_en = 1'b1;
  bit          arm_t3 = 1'b0;
  bit          stb_once = 1'b0;
  bit          stb_on_eof = 1'b0;
  int          obs_g[$];
  logic [N-1:0] prev_ack = '0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r,
                                 input int lst);
    for (int k = 1; k <= N; k++)
      for (int i = 0; i < N; i++)
        if (r[i] && (lst + k) % N == i) return i;
    return -1;
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < N; i++)
      if (src[i].size() != 0) return 1'b0;
    return owner < 0;
  endfunction

  task automatic push_pkt(input int i, input int beats,
                          input logic [W-1:0] base);
    for (int b = 0; b < beats; b++)
      src[i].push_back({b == beats - 1, base + W'(b)});
  endtask

  task automatic step();
    logic [N-1:0] req, exp_ack, exp_rdy;
    logic [W:0]   hd, t;
    bit           exp_vld, fire, eof;
    int           nxt, p;
    hd = '0;
    if (arm_t3 && owner == 1 && src[1].size() == 1 &&
        rdy && vld_en) begin
      push_pkt(2, 2, 64'h300);
      arm_t3 = 1'b0;
    end
    exp_vld = 1'b0;
    if (owner >= 0 && src[owner].size() > 0) begin
      hd      = src[owner][0];
      exp_vld = vld_en;
    end
    fire = exp_vld && rdy;
    eof  = fire && hd[W];
    rd_stb = stb_once || (stb_on_eof && eof);
    stb_once = 1'b0;
    if (eof) stb_on_eof = 1'b0;
    req = '0;
    for (int i = 0; i < N; i++) begin
      t = (src[i].size() > 0) ? src[i][0] : '0;
      req[i]                = src[i].size() > 0;
      bus.i_tvalid[i]       = vld_en && src[i].size() > 0;
      bus.i_tdata[i*W +: W] = t[W-1:0];
      bus.i_tlast[i]        = t[W];
    end
    bus.forward_req = req;
    bus.o_tready    = rdy;
    #1;
    for (int i = 0; i < N; i++) begin
      exp_ack[i] = (owner == i);
      exp_rdy[i] = (owner == i) && rdy;
    end
    chk("ack", bus.forward_ack, exp_ack);
    chk("busy", busy, owner >= 0);
    chk("o_tvalid", bus.o_tvalid, exp_vld);
    chk("i_tready", bus.i_tready, exp_rdy);
    chk("pkt_count", pkt_count, m_count);
    if (exp_vld) begin
      chk("o_tdata", bus.o_tdata, hd[W-1:0]);
      chk("o_tlast", bus.o_tlast, hd[W]);
    end
    if (bus.forward_ack != '0 && prev_ack == '0)
      for (int i = 0; i < N; i++)
        if (bus.forward_ack[i]) obs_g.push_back(i);
    prev_ack = bus.forward_ack;
    if (fire) void'(src[owner].pop_front());
    nxt = owner;
    if (reset || clear) begin
      nxt     = -1;
      m_last  = N - 1;
      m_count = '0;
    end else begin
      if (owner < 0) begin
        p = rr_pick(req, m_last);
        if (p >= 0) begin
          nxt    = p;
          m_last = p;
        end
      end else if (eof) begin
        nxt = -1;
      end
      if (rd_stb)
        m_count = {31'd0, eof};
      else if (eof && m_count != 32'hFFFF_FFFF)
        m_count = m_count + 32'd1;
    end
    owner = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int bound);
    int k;
    k = 0;
    while (!all_idle() && k < bound) begin
      step();
      k++;
    end
    chk("drain_done", all_idle(), 1);
  endtask

  initial begin
    int k;
    int ri;
    bus.forward_req = '0;
    bus.i_tdata     = '0;
    bus.i_tlast     = '0;
    bus.i_tvalid    = '0;
    bus.o_tready    = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b0;
    step();

    push_pkt(0, 3, 64'hA);
    step();
    chk("t1_ack_rise", bus.forward_ack, 4'b0001);
    run_until_idle(50);
    step();
    chk("t1_count", pkt_count, 1);
    chk("t1_ack_low", bus.forward_ack, 0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    obs_g.delete();
    for (int i = 0; i < N; i++) begin
      push_pkt(i, 2, 64'h100 * (i + 1));
      push_pkt(i, 2, 64'h1000 * (i + 1));
    end
    run_until_idle(100);
    chk("t2_ngrants", obs_g.size(), 8);
    for (int g = 0; g < 8 && g < obs_g.size(); g++)
      chk("t2_order", obs_g[g], g % N);
    chk("t2_count", pkt_count, 8);

    obs_g.delete();
    push_pkt(1, 2, 64'h200);
    arm_t3 = 1'b1;
    run_until_idle(50);
    chk("t3_ngrants", obs_g.size(), 2);
    if (obs_g.size() == 2) begin
      chk("t3_first", obs_g[0], 1);
      chk("t3_second", obs_g[1], 2);
    end

    push_pkt(0, 6, 64'h400);
    k = 0;
    while (!(owner == 0 && src[0].size() == 4) && k < 20) begin
      step();
      k++;
    end
    rdy = 1'b0;
    for (int c = 0; c < 10; c++) step();
    chk("t4_hold_ack", bus.forward_ack, 4'b0001);
    chk("t4_hold_rdy", bus.i_tready, 0);
    rdy = 1'b1;
    run_until_idle(50);

    push_pkt(3, 5, 64'h500);
    k = 0;
    while (!(owner == 3 && src[3].size() == 4) && k < 20) begin
      step();
      k++;
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    src[3].delete();
    chk("t5_ack", bus.forward_ack, 0);
    chk("t5_vld", bus.o_tvalid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_count", pkt_count, 0);
    step();

    for (int p = 0; p < 5; p++)
      push_pkt(p % N, 1, 64'h600 + 64'(p));
    run_until_idle(60);
    chk("t6_count5", pkt_count, 5);
    stb_once = 1'b1;
    step();
    chk("t6_cleared", pkt_count, 0);
    push_pkt(1, 1, 64'h6A0);
    stb_on_eof = 1'b1;
    run_until_idle(20);
    chk("t6_eof_in_clear", pkt_count, 1);

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        ri = $urandom_range(0, N - 1);
        if (src[ri].size() < 8)
          push_pkt(ri, $urandom_range(1, 4),
                   {$urandom, $urandom});
      end
      rdy      = $urandom_range(0, 3) != 0;
      vld_en   = $urandom_range(0, 3) != 0;
      stb_once = $urandom_range(0, 19) == 0;
      step();
    end
    rdy    = 1'b1;
    vld_en = 1'b1;
    run_until_idle(300);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_forwarding_arbiter.md
Name: axi_forwarding_arbiter

Overview:
- Output-side responder for the forwarding request/acknowledge protocol. One instance sits on each crossbar output (slave) port.
- Collects one forward request per crossbar input, i.e. bit j of each input's forwarding CAM forward_valid vector, and grants one request round-robin.
- Holds the grant as the acknowledge for the whole packet, muxing the granted input's AXI stream to the output. Releases the acknowledge on the EOF beat.
- Keeps a clear-on-read count of forwarded packets.

Parameters:
- WIDTH, 64, AXI stream data width in bits.
- NUM_INPUTS, 2, number of crossbar inputs (requesters), 1..16.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous soft clear, same effect as reset
- forward_req  in  NUM_INPUTS  bit i = input i's CAM forward_valid bit for this output
- forward_ack  out  NUM_INPUTS  bit i = acknowledge to input i's CAM (crossbar top ORs across outputs)
- i_tdata  in  NUM_INPUTS*WIDTH  input i occupies bits [i*WIDTH +: WIDTH]
- i_tlast  in  NUM_INPUTS  per-input last
- i_tvalid  in  NUM_INPUTS  per-input valid
- i_tready  out  NUM_INPUTS  per-input ready
- o_tdata  out  WIDTH  output data
- o_tlast  out  1  output last
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready
- busy  out  1  high while a grant is held
- pkt_count_rd_stb  in  1  readback strobe
- pkt_count  out  32  packets forwarded since the last read

Behaviour:
- Reset/clear values:
  - forward_ack = 0, busy = 0, state = IDLE, sel = 0.
  - last_grant = NUM_INPUTS-1, so input 0 has first priority.
  - pkt_count = 0.
- States: IDLE, GRANT.
- IDLE:
  - If forward_req != 0, choose the first set bit searching from last_grant+1 upward, wrapping modulo NUM_INPUTS.
  - Registered results: forward_ack = one-hot(sel), sel and last_grant = the chosen index, state = GRANT.
  - forward_ack is visible one cycle after the request is sampled.
- GRANT:
  - Datapath is combinational with zero latency: o_tdata/o_tlast/o_tvalid = the i_* signals of input sel, and i_tready[sel] = o_tready.
  - All other i_tready are 0. In IDLE, o_tvalid = 0 and all i_tready = 0.
  - On the cycle o_tvalid & o_tready & o_tlast, forward_ack <= 0 and state <= IDLE.
  - The acknowledge is therefore held for the entire packet, and the CAM's WAIT state exits after the EOF beat.
- Request/ack rules:
  - The requester drops forward_req the cycle after it sees forward_ack; the arbiter ignores forward_req while in GRANT.
  - forward_ack is held low for at least one cycle between grants, which is the IDLE cycle.
  - Back-to-back packets from different inputs have a 1-cycle bubble. The same input re-requesting follows the normal round-robin rules.
- Fairness: with all inputs requesting continuously, grants rotate 0,1,...,NUM_INPUTS-1,0. No input waits more than NUM_INPUTS-1 packets.
- A request that arrives in the same cycle as the EOF beat is evaluated in the following IDLE cycle.
- Single-beat packet (tlast on the first beat): GRANT lasts exactly one transfer cycle.
- o_tready low stalls the packet indefinitely; the grant holds and there is no timeout.
- Reset or clear mid-packet: immediately IDLE with ack 0. The remaining beats are not forwarded and the packet is truncated; the upstream clear is responsible for flushing.
- pkt_count:
  - Increments by 1 on each EOF beat in GRANT and saturates at 2^32-1.
  - The value is readable in the cycle pkt_count_rd_stb is high.
  - It clears on the next cycle. An EOF in that clear cycle is counted, so the result is 1 rather than 0.
- NUM_INPUTS = 1: arbitration is trivial; the protocol is otherwise identical.

Decomposition:
- Shared package: a state encoding constant (IDLE/GRANT) and a log2 helper for the sel width, reused by the forwarding CAM and the crossbar top.
- One natural sub-module: rr_priority_encoder.
  - Combinational; inputs req[NUM_INPUTS] and last[log2], outputs a one-hot grant and its index.
  - Reused by other crossbar arbiters.

Test Plan:
1. Reset, then forward_req = 2'b01; input 0 sends 3 beats (0xA,0xB,0xC, tlast on 0xC) -> forward_ack = 01 one cycle later; o_tdata carries A,B,C; ack drops after beat C; pkt_count = 1.
2. NUM_INPUTS = 4, all requests held high for 8 packets of 2 beats each -> grant order 0,1,2,3,0,1,2,3; a 1-cycle ack-low gap between grants.
3. forward_req = 0100 arrives on the EOF cycle of input 1's packet -> input 2 is granted one cycle after EOF; the request is not lost.
4. Hold o_tready low for 10 cycles mid-packet -> the grant is held, i_tready[sel] = 0, no beats are dropped or duplicated.
5. Assert clear on beat 2 of a 5-beat packet -> forward_ack = 0 and o_tvalid = 0 the next cycle; state IDLE; pkt_count = 0.
6. pkt_count_rd_stb pulse with count 5 -> pkt_count reads 5, then 0 next cycle; an EOF in that cycle gives 1.
